// File: rtl/hms_display.sv
// Converts a captured binary HH:MM:SS to BCD with a shift-add-3 engine and
// drives a 4-digit multiplexed active-low 7-segment display plus a colon.
module hms_display #(
    parameter int SCAN_DIV = 500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [18:0] HMS_time,
    input  logic        half_sec_pulse,
    input  logic        mode,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        colon,
    output logic        busy,
    output logic        digits_valid,
    output logic        range_err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [3:0] BLANK = 4'hF;

    logic [1:0]       state_reg;
    logic [2:0]       cnt_reg;
    logic             mode_reg;
    logic             err_pend_reg;
    logic             range_err_reg;
    logic             digits_valid_reg;
    logic             phase_reg;
    logic [15:0]      disp_reg;
    logic [PRE_W-1:0] pre_reg;
    logic [1:0]       idx_reg;
    logic [1:0]       idx_next;
    logic [3:0]       an_reg;
    logic [6:0]       seg_reg;
    logic             capture;
    logic             err_next;
    logic             unused_bits;

    // Index 0 = seconds, 1 = minutes, 2 = hours (zero-extended to 6 bits).
    logic [5:0] field [3];
    logic [7:0] bcd   [3];

    assign field[0]    = HMS_time[5:0];
    assign field[1]    = HMS_time[11:6];
    assign field[2]    = {1'b0, HMS_time[16:12]};
    assign unused_bits = ^HMS_time[18:17];

    assign capture  = (state_reg == IDLE) && half_sec_pulse;
    assign err_next = (HMS_time[16:12] > 5'd23) || (HMS_time[11:6] > 6'd59) ||
                      (HMS_time[5:0] > 6'd59);

    function automatic logic [7:0] add3(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b[3:0] >= 4'd5) r[3:0] = b[3:0] + 4'd3;
        if (b[7:4] >= 4'd5) r[7:4] = b[7:4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dabble
            logic [5:0] sh_reg;
            logic [7:0] bcd_reg;
            logic [7:0] adj;

            assign adj     = add3(bcd_reg);
            assign bcd[gi] = bcd_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    sh_reg  <= '0;
                    bcd_reg <= '0;
                end else if (capture) begin
                    sh_reg  <= field[gi];
                    bcd_reg <= '0;
                end else if (state_reg == SHIFT) begin
                    bcd_reg <= {adj[6:0], sh_reg[5]};
                    sh_reg  <= {sh_reg[4:0], 1'b0};
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            mode_reg         <= 1'b0;
            err_pend_reg     <= 1'b0;
            range_err_reg    <= 1'b0;
            digits_valid_reg <= 1'b0;
            disp_reg         <= {4{BLANK}};
        end else begin
            digits_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (half_sec_pulse) begin
                        state_reg    <= SHIFT;
                        cnt_reg      <= '0;
                        mode_reg     <= mode;
                        err_pend_reg <= err_next;
                    end
                end
                SHIFT: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd5) state_reg <= DONE;
                end
                DONE: begin
                    state_reg        <= IDLE;
                    range_err_reg    <= err_pend_reg;
                    digits_valid_reg <= 1'b1;
                    if (mode_reg)
                        disp_reg <= {bcd[1], bcd[0]};
                    else
                        disp_reg <= {(bcd[2][7:4] == 4'd0) ? BLANK : bcd[2][7:4],
                                     bcd[2][3:0], bcd[1]};
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Both an and seg follow the next index so they change on the same edge.
    assign idx_next = (pre_reg == PRE_LAST) ? idx_reg + 2'd1 : idx_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_reg   <= '0;
            idx_reg   <= '0;
            an_reg    <= 4'b1110;
            seg_reg   <= 7'h7F;
            phase_reg <= 1'b0;
        end else begin
            pre_reg   <= (pre_reg == PRE_LAST) ? '0 : pre_reg + 1'b1;
            idx_reg   <= idx_next;
            an_reg    <= ~(4'b0001 << idx_next);
            seg_reg   <= decode(disp_reg[idx_next*4 +: 4]);
            if (half_sec_pulse) phase_reg <= ~phase_reg;
        end
    end

    assign an           = an_reg;
    assign seg          = seg_reg;
    assign colon        = phase_reg;
    assign busy         = (state_reg != IDLE);
    assign digits_valid = digits_valid_reg;
    assign range_err    = range_err_reg;
endmodule

// File: doc/hms_display.md
# hms_display

- Downstream consumer of the `timing` block's `HMS_time` and `half_sec_pulse`.
- On each half-second pulse, captures the current time and converts the binary hour/minute/second fields to BCD with a multi-cycle shift-add-3 (double-dabble) engine.
- Drives a 4-digit, time-multiplexed, active-low 7-segment display plus a blinking colon.
- Flags out-of-range time fields so verification can catch upstream counter faults.

## Interface
Parameters:
- `SCAN_DIV`, 500: clock cycles per digit slot. At the 500 kHz system clock this gives 1 kHz per digit and a 250 Hz frame rate. Legal range is ≥2.

Ports:
- `clock`  in  1: system clock, single clock domain.
- `reset`  in  1: synchronous, active-high. All registers reset on the rising `clock` edge while high.
- `HMS_time`  in  19: `{2'b00, hours[16:12] (5b), minutes[11:6] (6b), seconds[5:0] (6b)}`, binary.
- `half_sec_pulse`  in  1: one-cycle strobe, every 250 000 cycles.
- `mode`  in  1: 0 selects HH:MM, 1 selects MM:SS. Sampled only at capture.
- `an`  out  4: digit anodes, one-hot, active-low. `an[0]` is the rightmost digit.
- `seg`  out  7: segments, active-low, bit order `{g,f,e,d,c,b,a}`.
- `colon`  out  1: colon LED, active-high.
- `busy`  out  1: conversion in progress.
- `digits_valid`  out  1: one-cycle pulse when the display register has just been updated.
- `range_err`  out  1: captured time is invalid (hours>23, minutes>59 or seconds>59). Held until the next update.

## Operation
Conversion FSM states: IDLE, SHIFT, DONE.
- **IDLE:**
  - On an edge with `half_sec_pulse`=1, latch `mode` and the three fields into shift registers.
  - Clear the BCD accumulators and set the shift counter to 0.
  - Go to SHIFT. `busy`=1 from this edge.
- **SHIFT:**
  - Each edge performs add-3 on every BCD nibble ≥5, then shifts all three fields left by one in parallel.
  - Hours use 2 nibbles, minutes and seconds use 2 nibbles each.
  - After the 6th SHIFT edge, go to DONE.
- **DONE:**
  - One edge copies the selected pair of fields into the 4-digit display register.
  - Mode 0 loads `{hrs_tens, hrs_ones, min_tens, min_ones}`. Mode 1 loads `{min_tens, min_ones, sec_tens, sec_ones}`.
  - Update `range_err`, pulse `digits_valid`, clear `busy`, and return to IDLE.
- **Out-of-range values** are converted as-is with no clamping. Hours 31 displays "31"; minutes 63 displays "63".
- **Leading-zero blank:** in mode 0, if `hrs_tens`=0, digit 3 shows blank (`seg`=7'h7F). There is no blanking in mode 1.
- **Overrun:** a `half_sec_pulse` arriving while `busy`=1 is ignored for capture. It still toggles the colon.
- **Colon:** the phase flop toggles on every `half_sec_pulse`, and `colon`=phase.
- **Scan prescaler:**
  - Counts 0..`SCAN_DIV`-1 continuously. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - `an` and `seg` are both registered from the index and the display register, so they always change on the same edge.
- **Segment decode** (active-low hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Blank is 7F.

## Timing
- **Reset values:**
  - FSM IDLE; prescaler 0; index 0.
  - `an`=4'b1110, `seg`=7'h7F.
  - Display register all-blank until the first update.
  - `colon`=0, `busy`=0, `digits_valid`=0, `range_err`=0.
- **Latency:** capture at edge E0; SHIFT at E1..E6; DONE at E7. `digits_valid` is high for the cycle after E7, and new digits are eligible from E7.
- **Scan delay:** the new digit appears on `seg` at the next edge where that digit's index is active.
- **`busy`:** high for exactly 7 cycles per conversion.
- **Reset mid-conversion:** aborts to IDLE. The display returns to blank and no `digits_valid` pulse is issued.
- **Simultaneous events:**
  - `half_sec_pulse` at E7 (DONE) is ignored for capture. `busy` is still 1 in that cycle.
  - The scan wrap and a display update on the same edge are both honoured. The scan uses the pre-update register on that edge.
- **Scan period:** each `an` value is held for exactly `SCAN_DIV` cycles. The full frame is 4·`SCAN_DIV` cycles.

## Test plan
- **Reset:** reset 5 cycles, release → `an`=1110, `seg`=7F, `colon`=0, `busy`=0, `range_err`=0, no `digits_valid` for 100 cycles.
- **Basic conversion, mode 0:** `HMS_time`=12:34:56 (19'h0C8B8), `mode`=0, one pulse →
  - `busy` high for 7 cycles, `digits_valid` 7 cycles after capture.
  - Over one frame, `seg` per digit 3..0 = 79, 24, 30, 19 ("1234").
  - `range_err`=0.
- **Mode 1 and blanking:**
  - 09:05:07 with `mode`=1 → "0507" (40, 12, 40, 78).
  - Same time with `mode`=0 → digit 3 is 7F, then 10, 40, 12 ("_905").
- **Range error:** hours=24, minutes=60, seconds=0, `mode`=0 → displays "2460", `range_err`=1. The next valid capture of 23:59:59 clears it and displays "2359".
- **Overrun and reset abort:**
  - Second pulse 3 cycles after the first → no second capture, `busy` still drops after 7 cycles, `colon` toggled twice.
  - Reset asserted at SHIFT cycle 4 → IDLE, display blank, no `digits_valid`.
- **Scan and colon:** with `SCAN_DIV`=4 →
  - `an` sequence 1110, 1101, 1011, 0111, each held 4 cycles, then wraps.
  - 4 pulses 250 000 cycles apart → `colon` reads 1, 0, 1, 0.
